// File: rtl/mux_pin_tester.sv
// Pin-level exerciser for the 2:1 mux pin wrapper: sweeps all 8 input vectors and checks pin7.
// Define MUX_PIN_TESTER_SYNC_EN to route pin7 through a 2-flop synchronizer before the compare.
module mux_pin_tester #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    inout  wire              pin4,
    output logic             pin4_dir,
    inout  wire              pin2,
    output logic             pin2_dir,
    inout  wire              pin1,
    output logic             pin1_dir,
    inout  wire              pin7,
    output logic             pin7_dir,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_seen,
    output logic [2:0]       fail_vec
);

`ifdef MUX_PIN_TESTER_SYNC_EN
    localparam int SETTLE_TOTAL = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_TOTAL = SETTLE_CYCLES;
`endif
    localparam int CNT_W  = (SETTLE_TOTAL > 1) ? $clog2(SETTLE_TOTAL) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'((SETTLE_TOTAL > 0) ? SETTLE_TOTAL - 1 : 0);
    localparam logic [LOOP_W-1:0] LAST_LOOP   = LOOP_W'(LOOPS - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    state_t             r_state;
    logic [2:0]         r_vec;
    logic [LOOP_W-1:0]  r_loop;
    logic [CNT_W-1:0]   r_settleCnt;
    logic               r_pin4Val;
    logic               r_pin2Val;
    logic               r_pin1Val;
    logic               r_pinDir;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_errCount;
    logic               r_failSeen;
    logic [2:0]         r_failVec;

    logic               w_pin7Sample;
    logic               w_expected;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_errNext;
    logic               w_lastVec;

`ifdef MUX_PIN_TESTER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // pin7 arrives from the other board asynchronously to our clock
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pin7;
            r_sync2 <= r_sync1;
        end
    end
    assign w_pin7Sample = r_sync2;
`else
    assign w_pin7Sample = pin7;
`endif

    assign w_expected = r_vec[2] ? r_vec[1] : r_vec[0];
    assign w_lastVec  = (r_vec == 3'd7) && (r_loop == LAST_LOOP);
    assign w_errNext  = (w_mismatch && (r_errCount != ERR_MAX)) ? r_errCount + ERR_W'(1) : r_errCount;

    // Equality test written so that an X/Z on pin7 falls through to a mismatch
    always_comb begin
        w_mismatch = 1'b1;
        if (w_pin7Sample == w_expected) begin
            w_mismatch = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vec       <= 3'd0;
            r_loop      <= '0;
            r_settleCnt <= '0;
            r_pin4Val   <= 1'b0;
            r_pin2Val   <= 1'b0;
            r_pin1Val   <= 1'b0;
            r_pinDir    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_errCount  <= '0;
            r_failSeen  <= 1'b0;
            r_failVec   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec      <= 3'd0;
                        r_loop     <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_errCount <= '0;
                        r_failSeen <= 1'b0;
                        r_failVec  <= 3'd0;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_pin4Val <= r_vec[0];
                    r_pin2Val <= r_vec[1];
                    r_pin1Val <= r_vec[2];
                    r_pinDir  <= 1'b0;
                    if (SETTLE_TOTAL == 0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settleCnt <= SETTLE_LOAD;
                        r_state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settleCnt == '0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settleCnt <= r_settleCnt - CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    r_errCount <= w_errNext;
                    if (w_mismatch && !r_failSeen) begin
                        r_failSeen <= 1'b1;
                        r_failVec  <= r_vec;
                    end
                    // The run ends straight back in IDLE; done/pass hold the verdict
                    if (w_lastVec) begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_pass   <= (w_errNext == '0);
                        r_pinDir <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_vec <= r_vec + 3'd1;
                        if (r_vec == 3'd7) begin
                            r_loop <= r_loop + LOOP_W'(1);
                        end
                        r_state <= S_DRIVE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pin4      = r_pinDir ? 1'bz : r_pin4Val;
    assign pin2      = r_pinDir ? 1'bz : r_pin2Val;
    assign pin1      = r_pinDir ? 1'bz : r_pin1Val;
    assign pin7      = 1'bz;
    assign pin4_dir  = r_pinDir;
    assign pin2_dir  = r_pinDir;
    assign pin1_dir  = r_pinDir;
    assign pin7_dir  = 1'b1;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_errCount;
    assign fail_seen = r_failSeen;
    assign fail_vec  = r_failVec;

endmodule
